// File: rtl/pipe_stage_buf.sv
// In-order DEPTH-entry stage buffer with valid/ready handshake and synchronous flush; 1-cycle latency, no bypass.
// Backpressure: in_ready depends only on registered occupancy, so out_ready never reaches in_ready combinationally.
module pipe_stage_buf #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  flushed_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  flushed_q, flushed_d;
    logic              push, pop;

    assign in_ready    = (count_q != FULL_CNT);
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign flushed_cnt = flushed_q;

    // Flush cancels any handshake in the same cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        flushed_d = flushed_q;
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            flushed_d = count_q;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            flushed_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            flushed_q <= flushed_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (DEPTH >= 1) else $error("pipe_stage_buf: DEPTH must be >= 1");
            assert (count_q <= FULL_CNT) else $error("pipe_stage_buf: occupancy above DEPTH");
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance driven with hand-computed vectors.
module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH = 2 instance
    logic       rst2, iv2, ir2, ov2, or2, fl2;
    logic [7:0] id2, od2;
    logic [1:0] cnt2, fc2;
    // DEPTH = 3 instance
    logic       rst3, iv3, ir3, ov3, or3, fl3;
    logic [7:0] id3, od3;
    logic [1:0] cnt3, fc3;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf #(.DATA_W(8), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2),
        .count(cnt2), .flushed_cnt(fc2)
    );

    pipe_stage_buf #(.DATA_W(8), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(rst3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .flush(fl3),
        .count(cnt3), .flushed_cnt(fc3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DEPTH=3 interleave: 1 = push next value, 0 = pop; expected count after each step.
    localparam int NSTEP = 14;
    logic op_tbl  [NSTEP] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   cnt_tbl [NSTEP] = '{1, 2, 1, 2, 1, 2, 3, 2, 3, 2, 3, 2, 1, 0};

    initial begin
        rst2 = 1'b1; iv2 = 1'b0; id2 = '0; or2 = 1'b0; fl2 = 1'b0;
        rst3 = 1'b1; iv3 = 1'b0; id3 = '0; or3 = 1'b0; fl3 = 1'b0;
        tick();
        tick();
        rst2 = 1'b0;
        rst3 = 1'b0;

        // Reset state
        check("rst_in_ready", ir2, 1);
        check("rst_out_valid", ov2, 0);
        check("rst_count", cnt2, 0);
        check("rst_flushed", fc2, 0);

        // 1: single beat, one-cycle latency
        iv2 = 1'b1; id2 = 8'hA5; or2 = 1'b1;
        check("t1_in_ready0", ir2, 1);
        tick();
        iv2 = 1'b0;
        check("t1_out_valid", ov2, 1);
        check("t1_out_data", od2, 8'hA5);
        check("t1_count1", cnt2, 1);
        check("t1_in_ready1", ir2, 1);
        tick();
        check("t1_count0", cnt2, 0);
        check("t1_out_valid0", ov2, 0);
        check("t1_in_ready2", ir2, 1);

        // 2: streaming at full rate
        or2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv2 = 1'b1; id2 = 8'(i);
            check("t2_in_ready", ir2, 1);
            if (i > 1) begin
                check("t2_out_valid", ov2, 1);
                check("t2_out_data", od2, 32'(i - 1));
                check("t2_count", cnt2, 1);
            end
            tick();
        end
        iv2 = 1'b0;
        check("t2_last_data", od2, 8'h08);
        tick();
        check("t2_drained", cnt2, 0);

        // 3: full buffer backpressure
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h11; tick();
        id2 = 8'h22; tick();
        id2 = 8'h33;
        check("t3_count_full", cnt2, 2);
        check("t3_in_ready_full", ir2, 0);
        check("t3_head", od2, 8'h11);
        tick();
        check("t3_not_accepted", cnt2, 2);
        check("t3_head_held", od2, 8'h11);
        or2 = 1'b1;
        check("t3_full_pop_ready", ir2, 0);
        tick();
        or2 = 1'b0;
        check("t3_after_pop_cnt", cnt2, 1);
        check("t3_in_ready_back", ir2, 1);
        check("t3_head2", od2, 8'h22);
        tick();
        iv2 = 1'b0;
        check("t3_33_accepted", cnt2, 2);
        or2 = 1'b1;
        check("t3_order_22", od2, 8'h22);
        tick();
        check("t3_order_33", od2, 8'h33);
        tick();
        check("t3_empty", cnt2, 0);

        // 5: flush with two entries and a live handshake
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h66; tick();
        id2 = 8'h77; tick();
        check("t5_full", cnt2, 2);
        id2 = 8'h88; or2 = 1'b1; fl2 = 1'b1;
        tick();
        fl2 = 1'b0; iv2 = 1'b0; or2 = 1'b0;
        check("t5_count", cnt2, 0);
        check("t5_out_valid", ov2, 0);
        check("t5_flushed", fc2, 2);
        check("t5_in_ready", ir2, 1);
        tick();
        check("t5_nothing_out", ov2, 0);
        iv2 = 1'b1; id2 = 8'h55;
        tick();
        iv2 = 1'b0;
        check("t5_55_valid", ov2, 1);
        check("t5_55_data", od2, 8'h55);
        check("t5_flushed_held", fc2, 2);
        or2 = 1'b1;
        tick();
        check("t5_55_popped", cnt2, 0);

        // 6: reset together with flush mid-stream at count = 1
        or2 = 1'b1;
        iv2 = 1'b1; id2 = 8'h01; tick();
        check("t6_count1", cnt2, 1);
        id2 = 8'h02; rst2 = 1'b1; fl2 = 1'b1;
        tick();
        rst2 = 1'b0; fl2 = 1'b0; iv2 = 1'b0;
        check("t6_count", cnt2, 0);
        check("t6_out_valid", ov2, 0);
        check("t6_flushed", fc2, 0);
        check("t6_in_ready", ir2, 1);
        iv2 = 1'b1; id2 = 8'h99; tick();
        iv2 = 1'b0;
        check("t6_post_valid", ov2, 1);
        check("t6_post_data", od2, 8'h99);
        tick();
        check("t6_post_drain", cnt2, 0);

        // Flush of one entry, then flush while empty
        or2 = 1'b0;
        iv2 = 1'b1; id2 = 8'h44; tick();
        iv2 = 1'b0; fl2 = 1'b1; tick();
        check("fl_one", fc2, 1);
        tick();
        fl2 = 1'b0;
        check("fl_empty", fc2, 0);
        check("fl_empty_cnt", cnt2, 0);

        // 4: DEPTH=3 interleaved pushes/pops with pointer wrap
        begin
            int next_in  = 1;
            int next_out = 1;
            for (int s = 0; s < NSTEP; s++) begin
                if (op_tbl[s]) begin
                    iv3 = 1'b1; or3 = 1'b0; id3 = 8'(next_in);
                    check("t4_in_ready", ir3, 1);
                    next_in++;
                end else begin
                    iv3 = 1'b0; or3 = 1'b1;
                    check("t4_out_valid", ov3, 1);
                    check("t4_out_data", od3, 32'(next_out));
                    next_out++;
                end
                tick();
                check("t4_count", cnt3, 32'(cnt_tbl[s]));
                if (cnt_tbl[s] == 3) check("t4_full_ready", ir3, 0);
            end
            iv3 = 1'b0; or3 = 1'b0;
            check("t4_all_out", 32'(next_out), 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage buffer for the in-order core. It replaces the bare struct registers between fetch, decode, execute, memory and writeback. It carries one packed stage payload (fetch_data_t, decode_data_t, execute_data_t, ...) per entry with a valid/ready handshake, a DEPTH-entry in-order queue and a synchronous flush for branch/jump redirect. There is no combinational path from input to output or from out_ready to in_ready, so stages can be chained without long timing paths.

Parameters:
DATA_W, 96, payload width in bits; set to $bits(<stage struct>) at instantiation.
DEPTH, 2, number of entries, >= 1; DEPTH = 2 gives full throughput under registered ready; non-power-of-two allowed.
CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, do not override.

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  upstream stage presents a payload.
in_ready  out  1  buffer can accept this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream consumes the head this cycle; low means stall.
out_data  out  DATA_W  head payload.
flush  in  1  discard all entries (redirect).
count  out  CNT_W  current occupancy, 0..DEPTH.
flushed_cnt  out  CNT_W  number of valid entries discarded by the most recent flush; held until the next flush.

Behaviour:
- Storage: mem[DEPTH] of DATA_W bits. Pointers rd_ptr and wr_ptr are each $clog2(DEPTH) wide, minimum 1 bit. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by power-of-two overflow.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is a function of registered state only.
- out_valid = (count != 0); out_data = mem[rd_ptr]. Both are registered state only, with no path from in_*.
- Latency: a push in cycle N gives out_valid and out_data in cycle N+1 at the earliest. There is no same-cycle bypass.
- Push: mem[wr_ptr] <= in_data; wr_ptr advances. Pop: rd_ptr advances.
- count: +1 on push only, -1 on pop only, unchanged on push & pop together. Simultaneous push and pop is legal whenever 0 < count < DEPTH.
- At count == DEPTH, in_ready = 0, so no push can occur even if out_ready = 1 in that cycle. in_ready rises the cycle after the pop.
- At count == 0, out_valid = 0 and out_ready is ignored. out_data is don't-care, and the bench must not check it.
- Payload ordering is strictly FIFO. A payload is never duplicated or dropped except by flush or reset.
- When out_valid = 1 and out_ready = 0, out_data is held stable until it is popped or flushed.
- Flush, cycle N:
  - Next state is count = 0, rd_ptr = wr_ptr = 0; flushed_cnt <= count (the value at cycle N).
  - Flush has priority: any push or pop in cycle N is cancelled and produces no effect. Upstream must treat in_ready as meaningless in a flush cycle.
  - out_valid = 0 from cycle N+1.
  - flush asserted while count == 0 gives flushed_cnt <= 0.
- Reset (sync, active-high, any cycle including mid-stream or together with flush): next state is count = 0, rd_ptr = wr_ptr = 0, flushed_cnt = 0.
  - Reset overrides flush and handshake.
  - mem contents are not reset.
  - Output values in the cycle after reset: in_ready = 1, out_valid = 0, count = 0, flushed_cnt = 0.
- DEPTH = 1: in_ready = !out_valid, so throughput is at most one beat every 2 cycles. This is legal and documented.
- An assertion (simulation only) fires if DEPTH < 1 or if count > DEPTH.

Test Plan:
1. Reset, then in_valid = 1, in_data = 0xA5 for one cycle with out_ready = 1 -> out_valid = 1 and out_data = 0xA5 exactly one cycle later; count goes 0→1→0; in_ready stays 1 throughout.
2. DEPTH = 2, out_ready = 1, stream in_data = 1..8 on 8 consecutive cycles -> out_data = 1..8 on 8 consecutive cycles starting 1 cycle later; in_ready never drops; count stays 1 in steady state.
3. DEPTH = 2, out_ready = 0, push 0x11, 0x22, then offer 0x33 -> count = 2, in_ready = 0, 0x33 not accepted. Then out_ready = 1 for one cycle -> 0x11 popped; the next cycle in_ready = 1, 0x33 is accepted, and the output order is 0x11, 0x22, 0x33.
4. DEPTH = 3, 7 pushes interleaved with pops (push, push, pop, push, pop, push, push, pop, ...) -> pointers wrap past index 2 to 0 and the output order equals the input order 1..7.
5. DEPTH = 2, holding 2 entries with in_valid = 1 and out_ready = 1, assert flush -> next cycle count = 0, out_valid = 0, flushed_cnt = 2, and neither payload appears at the output. A following push of 0x55 appears 1 cycle after it is accepted.
6. Assert reset during test 2 stream at count = 1, also with flush high in the same cycle -> next cycle count = 0, out_valid = 0, flushed_cnt = 0, in_ready = 1. A push after reset is delivered normally.
